// File: rtl/hdmi_capture.sv
// hdmi_capture: video-input receiver; measures line/frame geometry, locks, decimates into framebuffer writes.
// Define HDMI_CAPTURE_LOCK_EN to enable the SEARCH/MEASURE/LOCKED geometry lock machine.
module hdmi_capture #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int XDIV   = 2,
    parameter int YDIV   = 2
) (
    input  logic        clock25,
    input  logic        reset,
    input  logic        vid_de,
    input  logic        vid_hs,
    input  logic        vid_vs,
    input  logic [23:0] vid_d,
    output logic        wr_en,
    output logic [11:0] wr_x,
    output logic [11:0] wr_y,
    output logic [23:0] wr_rgb,
    output logic        frame_start,
    output logic        locked,
    output logic [11:0] meas_width,
    output logic [11:0] meas_height,
    output logic        geometry_err
);
    localparam int          XSH      = $clog2(XDIV);
    localparam int          YSH      = $clog2(YDIV);
    localparam logic [11:0] LINE_PX  = 12'(WIDTH * XDIV);
    localparam logic [12:0] WIDTH_L  = 13'(WIDTH);
    localparam logic [12:0] HEIGHT_L = 13'(HEIGHT);
    localparam logic [2:0]  XSUB_MAX = 3'(XDIV - 1);
    localparam logic [2:0]  YSUB_MAX = 3'(YDIV - 1);
    localparam logic [11:0] CNT_MAX  = '1;
`ifdef HDMI_CAPTURE_LOCK_EN
    localparam logic [11:0] FRAME_LN = 12'(HEIGHT * YDIV);

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_e;
`else
    typedef enum logic [1:0] {SEARCH, LOCKED} state_e;
`endif

    state_e      state_q, state_d;
    logic        de1_q, de2_q, vs1_q, vs2_q;
    logic [23:0] d1_q;
    logic [11:0] pcnt_q, pcnt_d;
    logic [11:0] lcnt_q, lcnt_d;
    logic [2:0]  xsub_q, xsub_d;
    logic [2:0]  ysub_q, ysub_d;
    logic        lines_ok_q, lines_ok_d;
    logic [11:0] meas_w_q, meas_w_d;
    logic [11:0] meas_h_q, meas_h_d;
    logic        gerr_q, gerr_d;
    logic        wr_en_q, wr_en_d;
    logic [11:0] wr_x_q, wr_x_d;
    logic [11:0] wr_y_q, wr_y_d;
    logic [23:0] wr_rgb_q, wr_rgb_d;
    logic        fs_q, fs_d;

    logic        de_rise, de_fall, vs_rise;
    logic [11:0] pix_idx, pix_x, pix_y;
    logic [2:0]  pix_xsub;
    logic [11:0] lcnt_inc, lcnt_eff;
    logic        line_bad, ok_eff, keep;
    logic        unused_hs;

    assign unused_hs = vid_hs;

    // Counters hold "seen so far" values; the pixel in stage 1 uses index 0 on a DE rise.
    always_comb begin
        de_rise  = de1_q & ~de2_q;
        de_fall  = ~de1_q & de2_q;
        vs_rise  = vs1_q & ~vs2_q;
        pix_idx  = de_rise ? '0 : pcnt_q;
        pix_xsub = de_rise ? '0 : xsub_q;
        pix_x    = pix_idx >> XSH;
        pix_y    = lcnt_q >> YSH;
        lcnt_inc = (lcnt_q == CNT_MAX) ? lcnt_q : lcnt_q + 12'd1;
        line_bad = de_fall && (pcnt_q != LINE_PX);
        lcnt_eff = de_fall ? lcnt_inc : lcnt_q;
        ok_eff   = lines_ok_q & ~line_bad;

        pcnt_d     = pcnt_q;
        xsub_d     = xsub_q;
        lcnt_d     = lcnt_q;
        ysub_d     = ysub_q;
        lines_ok_d = lines_ok_q;
        meas_w_d   = meas_w_q;
        meas_h_d   = meas_h_q;

        if (de1_q) begin
            pcnt_d = (pix_idx == CNT_MAX) ? pix_idx : pix_idx + 12'd1;
            xsub_d = (pix_xsub == XSUB_MAX) ? '0 : pix_xsub + 3'd1;
        end
        if (de_fall) begin
            meas_w_d   = pcnt_q;
            lcnt_d     = lcnt_inc;
            ysub_d     = (ysub_q == YSUB_MAX) ? '0 : ysub_q + 3'd1;
            lines_ok_d = ok_eff;
        end
        // A line ending in the same cycle is already folded into lcnt_eff/ok_eff.
        if (vs_rise) begin
            meas_h_d   = lcnt_eff;
            lcnt_d     = '0;
            ysub_d     = '0;
            xsub_d     = '0;
            lines_ok_d = 1'b1;
        end
    end

    always_comb begin
        keep = (state_q == LOCKED) && de1_q && (pix_xsub == '0) && (ysub_q == '0)
               && ({1'b0, pix_x} < WIDTH_L) && ({1'b0, pix_y} < HEIGHT_L);
        wr_en_d  = keep;
        fs_d     = keep && (pix_x == '0) && (pix_y == '0);
        wr_x_d   = keep ? pix_x : wr_x_q;
        wr_y_d   = keep ? pix_y : wr_y_q;
        wr_rgb_d = keep ? d1_q  : wr_rgb_q;
    end

    always_comb begin
        state_d = state_q;
        gerr_d  = 1'b0;
`ifdef HDMI_CAPTURE_LOCK_EN
        case (state_q)
            SEARCH:  if (vs_rise) state_d = MEASURE;
            MEASURE: if (vs_rise && (lcnt_eff == FRAME_LN) && ok_eff) state_d = LOCKED;
            LOCKED: begin
                if (line_bad || (vs_rise && (lcnt_eff != FRAME_LN))) begin
                    state_d = MEASURE;
                    gerr_d  = 1'b1;
                end
            end
            default: state_d = SEARCH;
        endcase
`else
        if ((state_q == SEARCH) && vs_rise) state_d = LOCKED;
`endif
    end

    always_ff @(posedge clock25 or posedge reset) begin
        if (reset) begin
            state_q    <= SEARCH;
            de1_q      <= 1'b0;
            de2_q      <= 1'b0;
            vs1_q      <= 1'b0;
            vs2_q      <= 1'b0;
            d1_q       <= '0;
            pcnt_q     <= '0;
            lcnt_q     <= '0;
            xsub_q     <= '0;
            ysub_q     <= '0;
            lines_ok_q <= 1'b0;
            meas_w_q   <= '0;
            meas_h_q   <= '0;
            gerr_q     <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_x_q     <= '0;
            wr_y_q     <= '0;
            wr_rgb_q   <= '0;
            fs_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            de1_q      <= vid_de;
            de2_q      <= de1_q;
            vs1_q      <= vid_vs;
            vs2_q      <= vs1_q;
            d1_q       <= vid_d;
            pcnt_q     <= pcnt_d;
            lcnt_q     <= lcnt_d;
            xsub_q     <= xsub_d;
            ysub_q     <= ysub_d;
            lines_ok_q <= lines_ok_d;
            meas_w_q   <= meas_w_d;
            meas_h_q   <= meas_h_d;
            gerr_q     <= gerr_d;
            wr_en_q    <= wr_en_d;
            wr_x_q     <= wr_x_d;
            wr_y_q     <= wr_y_d;
            wr_rgb_q   <= wr_rgb_d;
            fs_q       <= fs_d;
        end
    end

    assign wr_en        = wr_en_q;
    assign wr_x         = wr_x_q;
    assign wr_y         = wr_y_q;
    assign wr_rgb       = wr_rgb_q;
    assign frame_start  = fs_q;
    assign locked       = (state_q == LOCKED);
    assign meas_width   = meas_w_q;
    assign meas_height  = meas_h_q;
    assign geometry_err = gerr_q;
endmodule

// File: tb/tb_hdmi_capture.sv
// Scoreboard bench for hdmi_capture: an event-level frame model predicts writes and status.
module tb_hdmi_capture;
    localparam int W   = 4;
    localparam int H   = 3;
    localparam int XD  = 2;
    localparam int YD  = 2;
    localparam int LPX = W * XD;
    localparam int FLN = H * YD;
    localparam int M_SEARCH = 0;
    localparam int M_LOCKED = 2;
`ifdef HDMI_CAPTURE_LOCK_EN
    localparam int M_MEASURE = 1;
`endif

    logic        clock25 = 1'b0;
    logic        reset   = 1'b0;
    logic        vid_de  = 1'b0;
    logic        vid_hs  = 1'b0;
    logic        vid_vs  = 1'b0;
    logic [23:0] vid_d   = '0;
    logic        wr_en, frame_start, locked, geometry_err;
    logic [11:0] wr_x, wr_y, meas_width, meas_height;
    logic [23:0] wr_rgb;

    hdmi_capture #(.WIDTH(W), .HEIGHT(H), .XDIV(XD), .YDIV(YD)) dut (
        .clock25(clock25), .reset(reset), .vid_de(vid_de), .vid_hs(vid_hs),
        .vid_vs(vid_vs), .vid_d(vid_d), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y),
        .wr_rgb(wr_rgb), .frame_start(frame_start), .locked(locked),
        .meas_width(meas_width), .meas_height(meas_height), .geometry_err(geometry_err)
    );

    always #20 clock25 = ~clock25;

    int cyc = 0;
    always @(posedge clock25) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        int          x;
        int          y;
        logic [23:0] rgb;
        logic        fs;
    } exp_t;

    exp_t        expq[$];
    int          errors = 0, checks = 0;
    int          nwrites = 0, npushed = 0, obs_gerr = 0;
    logic [23:0] rgb12 = '0;

    // Frame-level reference model
    int m_state = M_SEARCH, m_lines = 0, m_mw = 0, m_mh = 0, m_gerr = 0;
    bit m_ok = 1'b0;

    task automatic m_line_end(input int n);
        m_mw = n;
        m_lines++;
        if (n != LPX) begin
            m_ok = 1'b0;
`ifdef HDMI_CAPTURE_LOCK_EN
            if (m_state == M_LOCKED) begin
                m_state = M_MEASURE;
                m_gerr++;
            end
`endif
        end
    endtask

    task automatic m_vsync();
        m_mh = m_lines;
`ifdef HDMI_CAPTURE_LOCK_EN
        if (m_state == M_SEARCH) m_state = M_MEASURE;
        else if (m_state == M_MEASURE) begin
            if (m_lines == FLN && m_ok) m_state = M_LOCKED;
        end else if (m_lines != FLN) begin
            m_state = M_MEASURE;
            m_gerr++;
        end
`else
        if (m_state == M_SEARCH) m_state = M_LOCKED;
`endif
        m_lines = 0;
        m_ok    = 1'b1;
    endtask

    task automatic m_reset();
        m_state = M_SEARCH;
        m_lines = 0;
        m_mw    = 0;
        m_mh    = 0;
        m_ok    = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_locked"}, 32'(locked), 32'(m_state == M_LOCKED));
        chk({tag, "_meas_width"}, 32'(meas_width), 32'(m_mw));
        chk({tag, "_meas_height"}, 32'(meas_height), 32'(m_mh));
    endtask

    task automatic tick();
        @(posedge clock25);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            vid_de = 1'b0;
            vid_vs = 1'b0;
            vid_d  = 24'($urandom);
            tick();
        end
    endtask

    task automatic vsync();
        vid_de = 1'b0;
        vid_vs = 1'b1;
        m_vsync();
        tick();
        tick();
        idle(2);
    endtask

    task automatic pix(input int i, input int l, input logic [23:0] d);
        exp_t e;
        vid_de = 1'b1;
        vid_vs = 1'b0;
        vid_d  = d;
        if (m_state == M_LOCKED && i % XD == 0 && l % YD == 0 && i / XD < W && l / YD < H) begin
            e.cyc = cyc + 2;
            e.x   = i / XD;
            e.y   = l / YD;
            e.rgb = d;
            e.fs  = (i == 0 && l == 0);
            expq.push_back(e);
            npushed++;
        end
        tick();
    endtask

    task automatic line(input int n, input bit pat, input bit vs_end);
        int l;
        l = m_lines;
        for (int i = 0; i < n; i++)
            pix(i, l, pat ? 24'((l << 8) | i) : 24'($urandom));
        vid_de = 1'b0;
        vid_vs = vs_end;
        vid_d  = 24'($urandom);
        m_line_end(n);
        if (vs_end) m_vsync();
        tick();
        if (vs_end) tick();
        idle($urandom_range(2, 4));
    endtask

    task automatic frame(input int nl, input int bad_idx, input int bad_w,
                         input bit pat, input bit lead_vs, input bit tail_vs);
        if (lead_vs) vsync();
        for (int l = 0; l < nl; l++)
            line((l == bad_idx) ? bad_w : LPX, pat, tail_vs && (l == nl - 1));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
        chk({tag, "_wr_x"}, 32'(wr_x), 32'd0);
        chk({tag, "_wr_y"}, 32'(wr_y), 32'd0);
        chk({tag, "_wr_rgb"}, 32'(wr_rgb), 32'd0);
        chk({tag, "_frame_start"}, 32'(frame_start), 32'd0);
        chk({tag, "_locked"}, 32'(locked), 32'd0);
        chk({tag, "_meas_width"}, 32'(meas_width), 32'd0);
        chk({tag, "_meas_height"}, 32'(meas_height), 32'd0);
        chk({tag, "_geometry_err"}, 32'(geometry_err), 32'd0);
    endtask

    always @(negedge clock25) begin
        exp_t e;
        if (!reset) begin
            if (geometry_err) obs_gerr++;
            if (wr_en) begin
                nwrites++;
                if (wr_x == 12'd1 && wr_y == 12'd2) rgb12 = wr_rgb;
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL write_unexpected cyc=%0d x=%0d y=%0d rgb=%06h", cyc, wr_x, wr_y, wr_rgb);
                end else begin
                    e = expq.pop_front();
                    if (cyc != e.cyc || int'(wr_x) != e.x || int'(wr_y) != e.y ||
                        wr_rgb !== e.rgb || frame_start !== e.fs) begin
                        errors++;
                        $display("FAIL write actual cyc=%0d x=%0d y=%0d rgb=%06h fs=%0b required cyc=%0d x=%0d y=%0d rgb=%06h fs=%0b",
                                 cyc, wr_x, wr_y, wr_rgb, frame_start, e.cyc, e.x, e.y, e.rgb, e.fs);
                    end
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, p0, nl, w;
        #1 reset = 1'b1;
        #5 check_all_zero("rst");
        #100;
        @(negedge clock25) reset = 1'b0;
        tick();

        // Three pattern frames, each led by its VS
        n0 = nwrites; p0 = npushed;
        frame(6, -1, 0, 1'b1, 1'b1, 1'b0);
        chk("frame1_writes", 32'(nwrites - n0), 32'(npushed - p0));
        n0 = nwrites; p0 = npushed;
        frame(6, -1, 0, 1'b1, 1'b1, 1'b0);
        chk("frame2_writes", 32'(nwrites - n0), 32'(npushed - p0));
        n0 = nwrites;
        frame(6, -1, 0, 1'b1, 1'b1, 1'b0);
        chk("frame3_writes", 32'(nwrites - n0), 32'd12);
        chk("rgb_at_1_2", 32'(rgb12), 32'h000402);
        check_status("f3");

        // Short line while locked
        n0 = nwrites; p0 = npushed;
        vsync();
        line(LPX, 1'b0, 1'b0);
        line(7, 1'b0, 1'b0);
        chk("short_meas_width", 32'(meas_width), 32'd7);
        check_status("short");
        chk("short_gerr", 32'(obs_gerr), 32'(m_gerr));
        for (int l = 0; l < 4; l++) line(LPX, 1'b0, 1'b0);
        chk("short_frame_writes", 32'(nwrites - n0), 32'(npushed - p0));
        frame(6, -1, 0, 1'b0, 1'b1, 1'b0);
        frame(6, -1, 0, 1'b0, 1'b1, 1'b0);
        chk("relocked", 32'(locked), 32'd1);
        check_status("relock");

        // DE fall and VS rise together on line 6
        frame(6, -1, 0, 1'b0, 1'b1, 1'b1);
        chk("simul_meas_height", 32'(meas_height), 32'd6);
        check_status("simul");
        n0 = nwrites; p0 = npushed;
        frame(6, -1, 0, 1'b0, 1'b0, 1'b0);
        chk("after_simul_writes", 32'(nwrites - n0), 32'(npushed - p0));
        check_status("after_simul");

        // Asynchronous reset mid-line while writing
        vsync();
        for (int i = 0; i < 5; i++) pix(i, 0, 24'($urandom));
        #10 reset = 1'b1;
        #1 check_all_zero("midreset");
        vid_de = 1'b0;
        expq.delete();
        m_reset();
        #100;
        @(negedge clock25) reset = 1'b0;
        tick();
        n0 = nwrites;
        frame(6, -1, 0, 1'b0, 1'b0, 1'b0);
        chk("post_reset_nowrites", 32'(nwrites - n0), 32'd0);
        n0 = nwrites; p0 = npushed;
        frame(6, -1, 0, 1'b0, 1'b1, 1'b0);
        chk("post_reset_frame_a", 32'(nwrites - n0), 32'(npushed - p0));
        n0 = nwrites;
        frame(6, -1, 0, 1'b0, 1'b1, 1'b0);
        chk("post_reset_frame_b", 32'(nwrites - n0), 32'd12);
        check_status("post_reset");

        // Over-wide frame: 9 px per line
        n0 = nwrites; p0 = npushed;
        vsync();
        for (int l = 0; l < 6; l++) line(9, 1'b0, 1'b0);
        chk("wide_writes", 32'(nwrites - n0), 32'(npushed - p0));
        chk("wide_gerr", 32'(obs_gerr), 32'(m_gerr));
        check_status("wide");

        // Randomized geometry
        for (int f = 0; f < 8; f++) begin
            vsync();
            nl = ($urandom % 4 == 0) ? $urandom_range(5, 7) : 6;
            for (int l = 0; l < nl; l++) begin
                w = ($urandom % 6 == 0) ? $urandom_range(7, 9) : LPX;
                line(w, 1'b0, 1'b0);
            end
            check_status("rand");
        end
        vsync();
        frame(6, -1, 0, 1'b0, 1'b1, 1'b0);

        idle(6);
        chk("queue_empty", 32'(expq.size()), 32'd0);
        chk("gerr_total", 32'(obs_gerr), 32'(m_gerr));
        check_status("end");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
